// File: rtl/uart_fifo_ctrl_if.sv
// uart_fifo_ctrl_if: byte-wide CPU bus between the processor and the UART controller.
// The master drives address, strobes and write data. The slave returns combinational read data.
interface uart_fifo_ctrl_if;
  logic [15:0] addr;
  logic        we;
  logic        re;
  logic [7:0]  di;
  logic [7:0]  dout;

  modport master (output addr, we, re, di, input dout);
  modport slave  (input addr, we, re, di, output dout);
endinterface

// File: rtl/uart_fifo_ctrl.sv
// uart_fifo_ctrl: memory-mapped UART controller.
// It contains RX/TX FIFOs, a TX sequencing FSM, a programmable baud divisor and sticky overflow
// flags. It occupies 8 bytes at BaseAddr.
// Optional feature: define UART_IRQ_EN to add the IRQEN register (offset 4) and a registered irq.
module uart_fifo_ctrl #(
  parameter logic [15:0] BaseAddr = 16'hFF10,
  parameter int unsigned Depth    = 16,
  parameter int unsigned ClkHz    = 50000000,
  parameter int unsigned Baud     = 115200
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_fifo_ctrl_if.slave    bus,
  input  logic [7:0]         uart_rx_data_i,
  input  logic               uart_rx_done_i,
  input  logic               uart_tx_done_i,
  output logic [7:0]         uart_tx_data_o,
  output logic               uart_transmit_o,
  output logic [15:0]        divisor_o,
  output logic               irq_o
);
  localparam int unsigned     PtrW       = $clog2(Depth);
  localparam int unsigned     CntW       = PtrW + 1;
  localparam logic [15:0]     DefaultDiv = 16'(ClkHz / Baud / 16);
  localparam logic [CntW-1:0] DepthCnt   = CntW'(Depth);

  typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} tx_state_e;

  // Address decode: only addr[15:3] selects the block.
  logic       sel;
  logic [2:0] off;
  logic       wr_data, wr_stat, wr_divlo, wr_divhi, rd_data;
  assign sel      = (bus.addr[15:3] == BaseAddr[15:3]);
  assign off      = bus.addr[2:0];
  assign wr_data  = bus.we & sel & (off == 3'd0);
  assign wr_stat  = bus.we & sel & (off == 3'd1);
  assign wr_divlo = bus.we & sel & (off == 3'd2);
  assign wr_divhi = bus.we & sel & (off == 3'd3);
  assign rd_data  = bus.re & sel & (off == 3'd0);

  // RX FIFO. A pop in the same cycle frees the slot for an incoming byte when full.
  logic [7:0]      rx_mem_q [Depth];
  logic [PtrW-1:0] rx_wptr_q, rx_rptr_q;
  logic [CntW-1:0] rx_cnt_q;
  logic            rx_nempty, rx_full, rx_pop, rx_push, rx_ovf_set;
  assign rx_nempty  = (rx_cnt_q != '0);
  assign rx_full    = (rx_cnt_q == DepthCnt);
  assign rx_pop     = rd_data & rx_nempty;
  assign rx_push    = uart_rx_done_i & (~rx_full | rx_pop);
  assign rx_ovf_set = uart_rx_done_i & rx_full & ~rx_pop;

  // TX FIFO. Pop is driven by the FSM in StLoad, which is entered only when non-empty.
  logic [7:0]      tx_mem_q [Depth];
  logic [PtrW-1:0] tx_wptr_q, tx_rptr_q;
  logic [CntW-1:0] tx_cnt_q;
  logic            tx_nempty, tx_empty, tx_full, tx_pop, tx_push, tx_ovf_set, tx_busy;
  assign tx_nempty  = (tx_cnt_q != '0);
  assign tx_empty   = ~tx_nempty;
  assign tx_full    = (tx_cnt_q == DepthCnt);
  assign tx_push    = wr_data & (~tx_full | tx_pop);
  assign tx_ovf_set = wr_data & tx_full & ~tx_pop;

  tx_state_e   state_q, state_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic [15:0] div_q, div_d;
  logic        rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d;
  logic [7:0]  irqen_rd;

  assign tx_busy        = (state_q != StIdle);
  assign uart_tx_data_o = tx_data_q;
  assign divisor_o      = div_q;

  // FIFO storage. The data arrays are not reset; pointers and counts define validity.
  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= uart_rx_data_i;
    if (tx_push) tx_mem_q[tx_wptr_q] <= bus.di;
  end

  // FIFO pointers and occupancy counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + PtrW'(1);
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrW'(1);
      rx_cnt_q <= rx_cnt_q + CntW'(rx_push) - CntW'(rx_pop);
      if (tx_push) tx_wptr_q <= tx_wptr_q + PtrW'(1);
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + PtrW'(1);
      tx_cnt_q <= tx_cnt_q + CntW'(tx_push) - CntW'(tx_pop);
    end
  end

  // TX sequencing: load the head byte, pulse transmit for one cycle, then wait for the core.
  always_comb begin
    state_d         = state_q;
    tx_data_d       = tx_data_q;
    tx_pop          = 1'b0;
    uart_transmit_o = 1'b0;
    unique case (state_q)
      StIdle:  if (tx_nempty) state_d = StLoad;
      StLoad: begin
        tx_pop    = 1'b1;
        tx_data_d = tx_mem_q[tx_rptr_q];
        state_d   = StStart;
      end
      StStart: begin
        uart_transmit_o = 1'b1;
        state_d         = StWait;
      end
      StWait:  if (uart_tx_done_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Sticky flags: a set event wins over a same-cycle W1C. The divisor bytes are written
  // independently.
  always_comb begin
    rx_ovf_d = rx_ovf_set | (rx_ovf_q & ~(wr_stat & bus.di[4]));
    tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~(wr_stat & bus.di[5]));
    div_d    = div_q;
    if (wr_divlo) div_d[7:0]  = bus.di;
    if (wr_divhi) div_d[15:8] = bus.di;
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      tx_data_q <= 8'h00;
      div_q     <= DefaultDiv;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      tx_data_q <= tx_data_d;
      div_q     <= div_d;
      rx_ovf_q  <= rx_ovf_d;
      tx_ovf_q  <= tx_ovf_d;
    end
  end

`ifdef UART_IRQ_EN
  logic [1:0] irqen_q;
  logic       irq_q;
  logic       wr_irqen;
  assign wr_irqen = bus.we & sel & (off == 3'd4);
  assign irqen_rd = {6'b0, irqen_q};
  assign irq_o    = irq_q;

  // Interrupt enables and registered level interrupt (one cycle behind its sources).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irqen_q <= 2'b00;
      irq_q   <= 1'b0;
    end else begin
      if (wr_irqen) irqen_q <= bus.di[1:0];
      irq_q <= (irqen_q[0] & rx_nempty) | (irqen_q[1] & tx_empty & ~tx_busy);
    end
  end
`else
  assign irqen_rd = 8'h00;
  assign irq_o    = 1'b0;
`endif

  // Read mux: combinational on the address, zero outside the window and at unused offsets.
  always_comb begin
    bus.dout = 8'h00;
    if (sel) begin
      case (off)
        3'd0:    bus.dout = rx_nempty ? rx_mem_q[rx_rptr_q] : 8'h00;
        3'd1:    bus.dout = {2'b00, tx_ovf_q, rx_ovf_q, tx_busy, tx_empty, tx_full, rx_nempty};
        3'd2:    bus.dout = div_q[7:0];
        3'd3:    bus.dout = div_q[15:8];
        3'd4:    bus.dout = irqen_rd;
        default: bus.dout = 8'h00;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb_uart_fifo_ctrl: self-checking bench for uart_fifo_ctrl.
// Queue-based reference model; the bench also acts as the UART core.
module tb_uart_fifo_ctrl;
  localparam int unsigned DEPTH = 16;
  localparam logic [15:0] BASE  = 16'hFF10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_done, uart_tx_done;
  logic [7:0]  uart_tx_data;
  logic        uart_transmit;
  logic [15:0] divisor;
  logic        irq;

  uart_fifo_ctrl_if bus ();

  uart_fifo_ctrl #(.BaseAddr(BASE), .Depth(DEPTH), .ClkHz(50000000), .Baud(115200)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .bus             (bus),
    .uart_rx_data_i  (uart_rx_data),
    .uart_rx_done_i  (uart_rx_done),
    .uart_tx_done_i  (uart_tx_done),
    .uart_tx_data_o  (uart_tx_data),
    .uart_transmit_o (uart_transmit),
    .divisor_o       (divisor),
    .irq_o           (irq)
  );

  always #5 clk = ~clk;

  int          compared = 0, mismatched = 0;
  logic [7:0]  rxq[$], txq[$];
  bit          rxovf_m, txovf_m;
  logic [15:0] div_m;
`ifdef UART_IRQ_EN
  logic [1:0]  irqen_m;
`endif
  logic [2:0]  tx_stat_exp;  // {busy, empty, full} expected when the bench knows the TX state
  logic [7:0]  stat_mask;
  bit          core_en, core_busy;
  int          core_delay, cyc, first_tx_cyc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rxq.delete();
    txq.delete();
    rxovf_m   = 0;
    txovf_m   = 0;
    div_m     = 16'd27;
`ifdef UART_IRQ_EN
    irqen_m   = 2'b00;
`endif
    core_busy = 0;
  endtask

  function automatic logic [7:0] exp_rd(input logic [15:0] a);
    if (a[15:3] != BASE[15:3]) return 8'h00;
    case (a[2:0])
      3'd0:    return (rxq.size() != 0) ? rxq[0] : 8'h00;
      3'd1:    return {2'b00, txovf_m, rxovf_m, tx_stat_exp, rxq.size() != 0};
      3'd2:    return div_m[7:0];
      3'd3:    return div_m[15:8];
`ifdef UART_IRQ_EN
      3'd4:    return {6'b0, irqen_m};
`endif
      default: return 8'h00;
    endcase
  endfunction

  // One clock: sample at negedge (read data, core side), then drive the next cycle after posedge.
  task automatic tick(output logic [7:0] rdata);
    @(negedge clk);
    cyc++;
    rdata = bus.dout;
    if (uart_transmit === 1'b1) begin
      if (first_tx_cyc < 0) first_tx_cyc = cyc;
      check_eq("tx_pending", txq.size() != 0, 1);
      check_eq("tx_while_busy", core_busy, 0);
      if (txq.size() != 0) check_eq("tx_data", uart_tx_data, txq.pop_front());
      core_busy  = 1;
      core_delay = $urandom_range(0, 4);
    end
    @(posedge clk);
    #1;
    bus.we = 0; bus.re = 0; uart_rx_done = 0; uart_tx_done = 0;
    if (core_busy && core_en) begin
      if (core_delay == 0) begin
        uart_tx_done = 1;
        core_busy    = 0;
      end else core_delay--;
    end else if (!core_busy && $urandom_range(0, 19) == 0) begin
      uart_tx_done = 1;  // stray pulse while the controller is not waiting
    end
  endtask

  task automatic cycle_op(input logic [15:0] a, input bit wr, input bit rd, input logic [7:0] wd,
                          input bit rxv, input logic [7:0] rxd, input string tag);
    logic [7:0] exp, mask, got;
    bit         insel, rx_set, tx_set;
    logic [2:0] off;
    insel = (a[15:3] == BASE[15:3]);
    off   = a[2:0];
    exp   = exp_rd(a);
    mask  = (insel && off == 3'd1) ? stat_mask : 8'hFF;
    bus.addr = a; bus.we = wr; bus.re = rd; bus.di = wd;
    uart_rx_done = rxv; uart_rx_data = rxd;
    tick(got);
    check_eq(tag, got & mask, exp & mask);
    rx_set = 0;
    tx_set = 0;
    if (insel && rd && off == 3'd0 && rxq.size() != 0) void'(rxq.pop_front());
    if (rxv) begin
      if (rxq.size() < DEPTH) rxq.push_back(rxd);
      else rx_set = 1;
    end
    if (insel && wr) begin
      case (off)
        3'd0: if (txq.size() < DEPTH) txq.push_back(wd); else tx_set = 1;
        3'd2: div_m[7:0]  = wd;
        3'd3: div_m[15:8] = wd;
`ifdef UART_IRQ_EN
        3'd4: irqen_m = wd[1:0];
`endif
        default: ;
      endcase
    end
    rxovf_m = rx_set | (rxovf_m & !(insel && wr && off == 3'd1 && wd[4]));
    txovf_m = tx_set | (txovf_m & !(insel && wr && off == 3'd1 && wd[5]));
    check_eq("divisor", divisor, div_m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_op(16'h0000, 0, 0, 8'h00, 0, 8'h00, "idle_rd");
  endtask

  task automatic wait_core_busy(input string tag);
    int n = 0;
    while (!core_busy && n < 20) begin
      idle(1);
      n++;
    end
    check_eq(tag, core_busy, 1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    core_en = 1;
    while ((txq.size() != 0 || core_busy) && n < 2000) begin
      idle(1);
      n++;
    end
    check_eq(tag, txq.size() + int'(core_busy), 0);
    idle(3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int wcyc;
    bus.addr = 16'h0; bus.we = 0; bus.re = 0; bus.di = 8'h0;
    uart_rx_data = 8'h0; uart_rx_done = 0; uart_tx_done = 0;
    core_en = 1; stat_mask = 8'hFF; tx_stat_exp = 3'b010; cyc = 0; first_tx_cyc = -1;
    model_reset();
    rst_n = 0;
    #12;
    bus.addr = BASE + 16'd1;
    #1;
    check_eq("rst_stat", bus.dout, exp_rd(bus.addr));
    check_eq("rst_div", divisor, div_m);
    check_eq("rst_transmit", uart_transmit, 0);
    check_eq("rst_tx_data", uart_tx_data, 8'h00);
    check_eq("rst_irq", irq, 0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;

    // Divisor registers
    cycle_op(BASE + 16'd2, 1, 0, 8'h00, 0, 8'h00, "div_lo_wr");
    cycle_op(BASE + 16'd3, 1, 0, 8'h01, 0, 8'h00, "div_hi_wr");
    check_eq("div_0100", divisor, 16'h0100);
    cycle_op(BASE + 16'd2, 0, 1, 8'h00, 0, 8'h00, "div_lo_rd");
    cycle_op(BASE + 16'd3, 0, 1, 8'h00, 0, 8'h00, "div_hi_rd");

    // T2: two bytes, latency to the first transmit pulse
    first_tx_cyc = -1;
    cycle_op(BASE, 1, 0, 8'h41, 0, 8'h00, "t2_wr0");
    wcyc = cyc;
    cycle_op(BASE, 1, 0, 8'h42, 0, 8'h00, "t2_wr1");
    idle(4);
    check_eq("t2_latency", first_tx_cyc - wcyc, 3);
    drain("t2_drain");
    tx_stat_exp = 3'b010;
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t2_stat");

    // T3: TX overflow with the core stalled
    core_en = 0;
    cycle_op(BASE, 1, 0, 8'h50, 0, 8'h00, "t3_first");
    wait_core_busy("t3_in_wait");
    for (int i = 0; i <= DEPTH; i++) cycle_op(BASE, 1, 0, 8'(8'h60 + i), 0, 8'h00, "t3_wr");
    tx_stat_exp = 3'b101;
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t3_stat_full");
    cycle_op(BASE + 16'd1, 1, 1, 8'h20, 0, 8'h00, "t3_w1c");
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t3_stat_clr");
    drain("t3_drain");
    tx_stat_exp = 3'b010;
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t3_stat_done");

    // T4: RX overflow and drain
    for (int i = 0; i <= DEPTH; i++) cycle_op(16'h0000, 0, 0, 8'h00, 1, 8'(i), "t4_rx");
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t4_stat_ovf");
    for (int i = 0; i < DEPTH; i++) cycle_op(BASE, 0, 1, 8'h00, 0, 8'h00, "t4_pop");
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t4_stat_empty");
    cycle_op(BASE, 0, 1, 8'h00, 0, 8'h00, "t4_empty_rd");
    cycle_op(BASE, 0, 1, 8'h00, 0, 8'h00, "t4_empty_rd2");
    cycle_op(BASE + 16'd1, 1, 0, 8'h10, 0, 8'h00, "t4_w1c");
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t4_stat_clr");

    // T5: full RX with simultaneous push and pop; then W1C racing a new overflow
    for (int i = 0; i < DEPTH; i++) cycle_op(16'h0000, 0, 0, 8'h00, 1, 8'(8'h80 + i), "t5_fill");
    cycle_op(BASE, 0, 1, 8'h00, 1, 8'hEE, "t5_pop_push");
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t5_stat_noovf");
    cycle_op(BASE + 16'd1, 1, 1, 8'h10, 1, 8'h99, "t5_w1c_race");
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t5_stat_sticky");
    for (int i = 0; i < DEPTH; i++) cycle_op(BASE, 0, 1, 8'h00, 0, 8'h00, "t5_pop");
    cycle_op(BASE + 16'd1, 1, 1, 8'h30, 0, 8'h00, "t5_w1c");
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t5_stat_end");

    // T1: reset while the FSM waits on the core
    cycle_op(BASE + 16'd2, 1, 0, 8'h34, 0, 8'h00, "t1_div_lo");
    cycle_op(BASE + 16'd3, 1, 0, 8'h12, 0, 8'h00, "t1_div_hi");
    core_en = 0;
    cycle_op(BASE, 1, 0, 8'h77, 1, 8'h3C, "t1_wr");
    cycle_op(BASE, 1, 0, 8'h78, 0, 8'h00, "t1_wr2");
    wait_core_busy("t1_in_wait");
    @(negedge clk);
    #2;
    rst_n = 0;
    bus.addr = BASE + 16'd1;
    uart_tx_done = 0;
    model_reset();
    core_en = 1;
    #1;
    check_eq("t1_transmit", uart_transmit, 0);
    check_eq("t1_tx_data", uart_tx_data, 8'h00);
    check_eq("t1_div", divisor, div_m);
    check_eq("t1_irq", irq, 0);
    check_eq("t1_stat", bus.dout, exp_rd(bus.addr));
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    idle(8);
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "t1_stat_after");

    // Randomized traffic; TX bits of STAT depend on FSM timing and are masked here
    stat_mask = 8'h31;
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] a;
      bit          wr, rd;
      if ($urandom_range(0, 9) != 0) a = BASE + 16'($urandom_range(0, 7));
      else begin
        a = 16'($urandom);
        if (a[15:3] == BASE[15:3]) a[15] = ~a[15];
      end
      wr = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 2) == 0);
      if (a[2:0] == 3'd4) wr = 0;
      if (a[15:3] == BASE[15:3] && a[2:0] == 3'd0 && txq.size() >= DEPTH) wr = 0;
      cycle_op(a, wr, rd, 8'($urandom), $urandom_range(0, 2) == 0, 8'($urandom), "rnd_rd");
    end
    stat_mask = 8'hFF;
    drain("rnd_drain");
    tx_stat_exp = 3'b010;
    cycle_op(BASE + 16'd1, 0, 1, 8'h00, 0, 8'h00, "rnd_stat_end");

`ifdef UART_IRQ_EN
    // T6: interrupt enables
    while (rxq.size() != 0) cycle_op(BASE, 0, 1, 8'h00, 0, 8'h00, "t6_flush");
    cycle_op(BASE + 16'd1, 1, 0, 8'h30, 0, 8'h00, "t6_w1c");
    cycle_op(BASE + 16'd4, 1, 0, 8'h01, 0, 8'h00, "t6_en_rx");
    idle(1);
    check_eq("t6_irq_idle", irq, 0);
    cycle_op(16'h0000, 0, 0, 8'h00, 1, 8'h5A, "t6_rx");
    check_eq("t6_irq_lag", irq, 0);
    idle(1);
    check_eq("t6_irq_rx", irq, 1);
    cycle_op(BASE, 0, 1, 8'h00, 0, 8'h00, "t6_pop");
    check_eq("t6_irq_pop_lag", irq, 1);
    idle(1);
    check_eq("t6_irq_pop", irq, 0);
    cycle_op(BASE + 16'd4, 1, 0, 8'h02, 0, 8'h00, "t6_en_tx");
    cycle_op(BASE + 16'd4, 0, 1, 8'h00, 0, 8'h00, "t6_en_rd");
    check_eq("t6_irq_tx", irq, 1);
    cycle_op(BASE + 16'd4, 1, 0, 8'h00, 0, 8'h00, "t6_dis");
    idle(1);
    check_eq("t6_irq_off", irq, 0);
`else
    cycle_op(BASE + 16'd4, 1, 1, 8'hFF, 0, 8'h00, "irqen_absent_wr");
    cycle_op(BASE + 16'd4, 0, 1, 8'h00, 0, 8'h00, "irqen_absent_rd");
    check_eq("irq_tied", irq, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
